// File: rtl/img_conv_pkg.sv
// img_conv_pkg: SoC command opcodes and host sequencer types.
// Shared by the command responder and the host-side sequencer.
package img_conv_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_SET_NROWS = 4'd1,
    OP_SET_NCOLS = 4'd2,
    OP_SET_SIGMA = 4'd3,
    OP_GET_NROWS = 4'd4,
    OP_GET_NCOLS = 4'd5,
    OP_GET_SIGMA = 4'd6,
    OP_IMG_RX    = 4'd7,
    OP_CONV      = 4'd8,
    OP_IMG_TX    = 4'd9
  } opcode_t;

  localparam int HOST_NPIX_W = 16;

  typedef logic [3:0] host_state_t;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SET_ROWS  = 4'd1;
  localparam logic [3:0] S_SET_COLS  = 4'd2;
  localparam logic [3:0] S_SET_SIGMA = 4'd3;
  localparam logic [3:0] S_RX_CMD    = 4'd4;
  localparam logic [3:0] S_RX_WAIT   = 4'd5;
  localparam logic [3:0] S_RX_DATA   = 4'd6;
  localparam logic [3:0] S_CONV_CMD  = 4'd7;
  localparam logic [3:0] S_CONV_WAIT = 4'd8;
  localparam logic [3:0] S_TX_CMD    = 4'd9;
  localparam logic [3:0] S_TX_WAIT   = 4'd10;
  localparam logic [3:0] S_TX_DATA   = 4'd11;
  localparam logic [3:0] S_DONE      = 4'd12;

endpackage

// File: rtl/img_conv_host_seq_pix_ctr.sv
// img_host_pix_ctr: pixel index counter with final-pixel flag.
// One instance addresses RX reads, another counts TX results.
module img_host_pix_ctr
  import img_conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   inc,
  input  logic [HOST_NPIX_W-1:0] n,
  output logic [HOST_NPIX_W-1:0] idx,
  output logic                   last
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == n - 1'b1);

endmodule

// File: rtl/img_conv_host_seq.sv
// img_conv_host_seq: runs one blur job over the SoC command port.
// Define HOST_READBACK_EN to read back and verify each SET value.
module img_conv_host_seq
  import img_conv_pkg::*;
#(
  parameter int RX_SKIP = 1,
  parameter int TX_SKIP = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [7:0]  cfg_nrows,
  input  logic [7:0]  cfg_ncols,
  input  logic [2:0]  cfg_sigma,
  output logic        seq_busy,
  output logic        done,
  output logic        error,
  output logic        pix_rd_en,
  output logic [15:0] pix_rd_addr,
  input  logic [7:0]  pix_rd_data,
  output logic        pix_out_valid,
  output logic [7:0]  pix_out_data,
  output logic        pix_out_last,
  output logic        conv_en,
  output opcode_t     conv_op,
  output logic [7:0]  conv_din,
  input  logic [7:0]  conv_dout,
  input  logic        conv_busy
);

  host_state_t            state_q;
  logic [2:0]             step_q;
  logic [7:0]             nrows_q;
  logic [7:0]             ncols_q;
  logic [2:0]             sigma_q;
  logic [HOST_NPIX_W-1:0] npix_q;
  logic [7:0]             k_q;
  logic                   seen_q;
  logic                   rd_vld_q;
  logic                   rd_all_q;
  logic [7:0]             din_q;

  logic [HOST_NPIX_W-1:0] rd_idx;
  logic [HOST_NPIX_W-1:0] tx_idx;
  logic                   rd_last;
  logic                   tx_last;
  logic                   tx_full;
  logic                   ctr_clr;
  logic                   in_rx;
  logic                   in_tx;
  logic                   can_issue;
  logic                   rx_go;
  logic                   tx_go;
  logic                   tx_take;

  opcode_t                set_op;
  opcode_t                get_op;
  logic [7:0]             set_val;
  host_state_t            set_nxt;

  assign ctr_clr   = (state_q == S_IDLE);
  assign in_rx     = (state_q == S_RX_WAIT) || (state_q == S_RX_DATA);
  assign in_tx     = (state_q == S_TX_WAIT) || (state_q == S_TX_DATA);
  assign can_issue = !conv_busy && !conv_en;
  assign seq_busy  = (state_q != S_IDLE);

  // k_q is the index of the current busy-high cycle
  assign rx_go = ({1'b0, k_q} + 9'd1) >= 9'(RX_SKIP);
  assign tx_go = ({1'b0, k_q} + 9'd1) > 9'(TX_SKIP);

  assign pix_rd_en   = in_rx && conv_busy && rx_go && !rd_all_q;
  assign pix_rd_addr = rd_idx;
  assign conv_din    = rd_vld_q ? pix_rd_data : din_q;

  assign tx_full = (tx_idx == npix_q);
  assign tx_take = in_tx && conv_busy && tx_go && !tx_full;

  img_host_pix_ctr u_rd_ctr (
    .clk   (clk),
    .rstn  (rstn),
    .clear (ctr_clr),
    .inc   (pix_rd_en),
    .n     (npix_q),
    .idx   (rd_idx),
    .last  (rd_last)
  );

  img_host_pix_ctr u_tx_ctr (
    .clk   (clk),
    .rstn  (rstn),
    .clear (ctr_clr),
    .inc   (tx_take),
    .n     (npix_q),
    .idx   (tx_idx),
    .last  (tx_last)
  );

  always_comb begin
    set_op  = OP_NOP;
    get_op  = OP_NOP;
    set_val = 8'd0;
    set_nxt = S_IDLE;
    case (state_q)
      S_SET_ROWS: begin
        set_op  = OP_SET_NROWS;
        get_op  = OP_GET_NROWS;
        set_val = nrows_q;
        set_nxt = S_SET_COLS;
      end
      S_SET_COLS: begin
        set_op  = OP_SET_NCOLS;
        get_op  = OP_GET_NCOLS;
        set_val = ncols_q;
        set_nxt = S_SET_SIGMA;
      end
      S_SET_SIGMA: begin
        set_op  = OP_SET_SIGMA;
        get_op  = OP_GET_SIGMA;
        set_val = {5'd0, sigma_q};
        set_nxt = S_RX_CMD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      step_q        <= 3'd0;
      nrows_q       <= 8'd0;
      ncols_q       <= 8'd0;
      sigma_q       <= 3'd0;
      npix_q        <= '0;
      k_q           <= 8'd0;
      seen_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_all_q      <= 1'b0;
      din_q         <= 8'd0;
      conv_en       <= 1'b0;
      conv_op       <= OP_NOP;
      done          <= 1'b0;
      error         <= 1'b0;
      pix_out_valid <= 1'b0;
      pix_out_data  <= 8'd0;
      pix_out_last  <= 1'b0;
    end else begin
      conv_en       <= 1'b0;
      conv_op       <= OP_NOP;
      done          <= 1'b0;
      pix_out_valid <= 1'b0;
      pix_out_last  <= 1'b0;
      rd_vld_q      <= pix_rd_en;

      if (ctr_clr) begin
        rd_all_q <= 1'b0;
      end else if (pix_rd_en && rd_last) begin
        rd_all_q <= 1'b1;
      end

      if ((in_rx || in_tx) && conv_busy && k_q != 8'hFF) begin
        k_q <= k_q + 8'd1;
      end

      if (tx_take) begin
        pix_out_valid <= 1'b1;
        pix_out_data  <= conv_dout;
        pix_out_last  <= tx_last;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            nrows_q <= cfg_nrows;
            ncols_q <= cfg_ncols;
            sigma_q <= cfg_sigma;
            npix_q  <= 16'(cfg_nrows) * 16'(cfg_ncols);
            error   <= 1'b0;
            step_q  <= 3'd0;
            if (cfg_nrows == 8'd0 || cfg_ncols == 8'd0) begin
              error   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SET_ROWS;
            end
          end
        end
        S_SET_ROWS, S_SET_COLS, S_SET_SIGMA: begin
          unique case (step_q)
            3'd0: begin
              if (can_issue) begin
                conv_en <= 1'b1;
                conv_op <= set_op;
                din_q   <= set_val;
                step_q  <= 3'd1;
              end
            end
            3'd1: begin
`ifdef HOST_READBACK_EN
              step_q  <= 3'd2;
`else
              step_q  <= 3'd0;
              state_q <= set_nxt;
`endif
            end
            3'd2: begin
              if (can_issue) begin
                conv_en <= 1'b1;
                conv_op <= get_op;
                step_q  <= 3'd3;
              end
            end
            3'd3: step_q <= 3'd4;
            3'd4: begin
              // responder answers the cycle after the GET strobe
              step_q <= 3'd0;
              if (conv_dout != set_val) begin
                error   <= 1'b1;
                state_q <= S_DONE;
              end else begin
                state_q <= set_nxt;
              end
            end
            default: step_q <= 3'd0;
          endcase
        end
        S_RX_CMD: begin
          if (can_issue) begin
            conv_en <= 1'b1;
            conv_op <= OP_IMG_RX;
            din_q   <= 8'd0;
            k_q     <= 8'd0;
            state_q <= S_RX_WAIT;
          end
        end
        S_RX_WAIT: begin
          if (conv_busy) state_q <= S_RX_DATA;
        end
        S_RX_DATA: begin
          if (!conv_busy) begin
            state_q <= S_CONV_CMD;
            // a read still in flight means its pixel missed the window
            if (!rd_all_q || rd_vld_q) error <= 1'b1;
          end
        end
        S_CONV_CMD: begin
          if (can_issue) begin
            conv_en <= 1'b1;
            conv_op <= OP_CONV;
            seen_q  <= 1'b0;
            state_q <= S_CONV_WAIT;
          end
        end
        S_CONV_WAIT: begin
          if (conv_busy) begin
            seen_q <= 1'b1;
          end else if (seen_q) begin
            state_q <= S_TX_CMD;
          end
        end
        S_TX_CMD: begin
          if (can_issue) begin
            conv_en <= 1'b1;
            conv_op <= OP_IMG_TX;
            k_q     <= 8'd0;
            state_q <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (conv_busy) state_q <= S_TX_DATA;
        end
        S_TX_DATA: begin
          if (!conv_busy) state_q <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_conv_host_seq.sv
// tb_img_conv_host_seq: host sequencer against a small SoC responder model.
// Scoreboard queues hold expected RX pixels and TX results.
module tb_img_conv_host_seq;
  import img_conv_pkg::*;

  localparam int RX_SKIP = 1;
  localparam int TX_SKIP = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_nrows = 8'd0;
  logic [7:0]  cfg_ncols = 8'd0;
  logic [2:0]  cfg_sigma = 3'd0;
  logic        seq_busy;
  logic        done;
  logic        error;
  logic        pix_rd_en;
  logic [15:0] pix_rd_addr;
  logic [7:0]  pix_rd_data = 8'd0;
  logic        pix_out_valid;
  logic [7:0]  pix_out_data;
  logic        pix_out_last;
  logic        conv_en;
  opcode_t     conv_op;
  logic [7:0]  conv_din;
  logic [7:0]  conv_dout;
  logic        conv_busy;

  always #5 clk = ~clk;

  img_conv_host_seq #(.RX_SKIP(RX_SKIP), .TX_SKIP(TX_SKIP)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .cfg_nrows     (cfg_nrows),
    .cfg_ncols     (cfg_ncols),
    .cfg_sigma     (cfg_sigma),
    .seq_busy      (seq_busy),
    .done          (done),
    .error         (error),
    .pix_rd_en     (pix_rd_en),
    .pix_rd_addr   (pix_rd_addr),
    .pix_rd_data   (pix_rd_data),
    .pix_out_valid (pix_out_valid),
    .pix_out_data  (pix_out_data),
    .pix_out_last  (pix_out_last),
    .conv_en       (conv_en),
    .conv_op       (conv_op),
    .conv_din      (conv_din),
    .conv_dout     (conv_dout),
    .conv_busy     (conv_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pixel source memory, one-cycle read latency
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (pix_rd_en) pix_rd_data <= mem[pix_rd_addr[7:0]];
  end

  // SoC responder model
  logic       busy_m;
  logic [7:0] dout_m;
  int         mode_m;
  int         mk;
  int         mlen;
  int         m_npix;
  logic [7:0] m_nrows;
  logic [7:0] m_ncols;
  logic [7:0] m_sigma;
  int         rx_drop = -1;
  bit         bad_rows = 1'b0;

  logic [7:0] rx_exp [$];
  logic [8:0] sb [$];
  opcode_t    op_log [$];
  logic [7:0] din_log [$];
  int         en_cnt = 0;
  int         done_cnt = 0;
  int         tx_cnt = 0;

  assign conv_busy = busy_m;
  assign conv_dout = dout_m;

  function automatic logic [7:0] res(input int j);
    return 8'(j * 7 + 1);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_m  <= 1'b0;
      dout_m  <= 8'd0;
      mode_m  <= 0;
      mk      <= 0;
      mlen    <= 0;
      m_npix  <= 0;
      m_nrows <= 8'd0;
      m_ncols <= 8'd0;
      m_sigma <= 8'd0;
    end else begin
      if (busy_m) begin
        if (mk + 1 >= mlen) begin
          busy_m <= 1'b0;
          mode_m <= 0;
        end
        mk <= mk + 1;
        if (mode_m == 3 && mk + 1 < mlen &&
            mk + 1 - TX_SKIP >= 0 && mk + 1 - TX_SKIP < m_npix) begin
          dout_m <= res(mk + 1 - TX_SKIP);
          sb.push_back({(mk + 1 - TX_SKIP == m_npix - 1),
                        res(mk + 1 - TX_SKIP)});
        end
      end
      if (conv_en) begin
        case (conv_op)
          OP_SET_NROWS: m_nrows <= conv_din;
          OP_SET_NCOLS: m_ncols <= conv_din;
          OP_SET_SIGMA: m_sigma <= conv_din;
          OP_GET_NROWS: dout_m <= bad_rows ? m_nrows - 8'd1 : m_nrows;
          OP_GET_NCOLS: dout_m <= m_ncols;
          OP_GET_SIGMA: dout_m <= m_sigma;
          OP_IMG_RX: begin
            busy_m <= 1'b1;
            mode_m <= 1;
            mk     <= 0;
            mlen   <= (rx_drop >= 0) ? RX_SKIP + rx_drop
                      : RX_SKIP + int'(m_nrows) * int'(m_ncols);
          end
          OP_CONV: begin
            busy_m <= 1'b1;
            mode_m <= 2;
            mk     <= 0;
            mlen   <= 3;
          end
          OP_IMG_TX: begin
            busy_m <= 1'b1;
            mode_m <= 3;
            mk     <= 0;
            m_npix <= int'(m_nrows) * int'(m_ncols);
            mlen   <= TX_SKIP + int'(m_nrows) * int'(m_ncols) + 2;
          end
          default: ;
        endcase
      end
    end
  end

  // monitor, sampled mid-cycle
  logic [8:0] sb_e;
  always @(negedge clk) begin
    if (conv_en) begin
      op_log.push_back(conv_op);
      din_log.push_back(conv_din);
      en_cnt++;
    end
    if (done) done_cnt++;
    if (rstn && mode_m == 1 && busy_m && mk >= RX_SKIP) begin
      if (rx_exp.size() == 0) chk("rx_extra", 32'd1, 32'd0);
      else chk("rx_pix", 32'(conv_din), 32'(rx_exp.pop_front()));
    end
    if (pix_out_valid) begin
      tx_cnt++;
      if (sb.size() == 0) begin
        chk("tx_extra", 32'd1, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("tx_pix", 32'(pix_out_data), 32'(sb_e[7:0]));
        chk("tx_last", 32'(pix_out_last), 32'(sb_e[8]));
      end
    end
  end

  task automatic prep(input int n);
    sb.delete();
    rx_exp.delete();
    for (int i = 0; i < n; i++) begin
      mem[i] = 8'(10 + i);
      rx_exp.push_back(8'(10 + i));
    end
  endtask

  task automatic run_job(input logic [7:0] nr, input logic [7:0] nc,
                         input logic [2:0] sg, input bit poke,
                         output int lat, output int en_lat);
    bit poked;
    prep(int'(nr) * int'(nc));
    @(negedge clk);
    cfg_nrows = nr;
    cfg_ncols = nc;
    cfg_sigma = sg;
    start = 1'b1;
    lat = 0;
    en_lat = -1;
    poked = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (lat == 1) chk("seq_busy", 32'(seq_busy), 32'd1);
      if (conv_en && en_lat < 0) en_lat = lat;
      if (poke && !poked && mode_m == 1) begin
        start = 1'b1;
        cfg_ncols = 8'd0;
        poked = 1'b1;
      end
    end while (!done && lat < 2000);
    if (!done) chk("job_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  opcode_t    exp_op [6];
  logic [7:0] exp_din [3];
  int lat, enl, d0, e0, t0, log0, nn, nrx, wait_n;

  initial begin
    exp_op = '{OP_SET_NROWS, OP_SET_NCOLS, OP_SET_SIGMA,
               OP_IMG_RX, OP_CONV, OP_IMG_TX};
    exp_din = '{8'd2, 8'd3, 8'd2};

    repeat (3) @(negedge clk);
    chk("rst_bits", 32'({seq_busy, done, error, pix_rd_en,
                         pix_out_valid, pix_out_last, conv_en}), 32'd0);
    chk("rst_addr", 32'(pix_rd_addr), 32'd0);
    chk("rst_data", 32'({pix_out_data, conv_din}), 32'd0);
    chk("rst_op", 32'(conv_op), 32'(OP_NOP));
    rstn = 1'b1;

    // 2x3 job, sigma 2
    d0 = done_cnt; log0 = op_log.size(); t0 = tx_cnt;
    run_job(8'd2, 8'd3, 3'd2, 1'b0, lat, enl);
    chk("first_en", 32'(enl), 32'd2);
    chk("job_err", 32'(error), 32'd0);
    chk("job_done", 32'(done_cnt - d0), 32'd1);
    chk("job_tx_cnt", 32'(tx_cnt - t0), 32'd6);
    chk("job_sb_left", 32'(sb.size()), 32'd0);
    chk("job_rx_left", 32'(rx_exp.size()), 32'd0);
    nn = 0;
    for (int i = log0; i < op_log.size(); i++) begin
      if (op_log[i] inside {OP_GET_NROWS, OP_GET_NCOLS, OP_GET_SIGMA})
        continue;
      if (nn < 6) chk("cmd_op", 32'(op_log[i]), 32'(exp_op[nn]));
      if (nn < 3) chk("cmd_din", 32'(din_log[i]), 32'(exp_din[nn]));
      nn++;
    end
    chk("cmd_cnt", 32'(nn), 32'd6);

    // zero dimension
    d0 = done_cnt; e0 = en_cnt;
    run_job(8'd4, 8'd0, 3'd1, 1'b0, lat, enl);
    chk("zero_lat", 32'(lat), 32'd2);
    chk("zero_err", 32'(error), 32'd1);
    chk("zero_en", 32'(en_cnt - e0), 32'd0);
    chk("zero_done", 32'(done_cnt - d0), 32'd1);

    // start pulsed again during RX
    d0 = done_cnt;
    run_job(8'd3, 8'd2, 3'd5, 1'b1, lat, enl);
    chk("poke_err", 32'(error), 32'd0);
    chk("poke_done", 32'(done_cnt - d0), 32'd1);
    chk("poke_sb_left", 32'(sb.size()), 32'd0);
    chk("poke_rx_left", 32'(rx_exp.size()), 32'd0);

    // reset during TX
    prep(6);
    @(negedge clk);
    cfg_nrows = 8'd2; cfg_ncols = 8'd3; cfg_sigma = 3'd3;
    start = 1'b1;
    wait_n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      wait_n++;
    end while (!pix_out_valid && wait_n < 2000);
    chk("rst_saw_tx", 32'(pix_out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_bits", 32'({seq_busy, done, error, pix_rd_en,
                             pix_out_valid, pix_out_last, conv_en}), 32'd0);
    chk("mid_rst_addr", 32'(pix_rd_addr), 32'd0);
    chk("mid_rst_data", 32'({pix_out_data, conv_din}), 32'd0);
    chk("mid_rst_op", 32'(conv_op), 32'(OP_NOP));
    @(negedge clk);
    rstn = 1'b1;
    d0 = done_cnt; t0 = tx_cnt;
    run_job(8'd2, 8'd3, 3'd1, 1'b0, lat, enl);
    chk("after_rst_err", 32'(error), 32'd0);
    chk("after_rst_done", 32'(done_cnt - d0), 32'd1);
    chk("after_rst_tx", 32'(tx_cnt - t0), 32'd6);

    // responder drops busy after 3 of 6 pixels
    rx_drop = 3;
    d0 = done_cnt;
    run_job(8'd2, 8'd3, 3'd2, 1'b0, lat, enl);
    rx_drop = -1;
    chk("drop_err", 32'(error), 32'd1);
    chk("drop_done", 32'(done_cnt - d0), 32'd1);
    chk("drop_rx_left", 32'(rx_exp.size()), 32'd3);

`ifdef HOST_READBACK_EN
    // corrupted nrows readback
    bad_rows = 1'b1;
    d0 = done_cnt; log0 = op_log.size();
    run_job(8'd8, 8'd2, 3'd3, 1'b0, lat, enl);
    bad_rows = 1'b0;
    nrx = 0;
    for (int i = log0; i < op_log.size(); i++) begin
      if (op_log[i] == OP_IMG_RX) nrx++;
    end
    chk("rb_err", 32'(error), 32'd1);
    chk("rb_done", 32'(done_cnt - d0), 32'd1);
    chk("rb_no_rx", 32'(nrx), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
